// File: rtl/display_scan_controller.sv
// Four-digit multiplexed 7-segment scanner with ghost blanking, PWM brightness,
// leading-zero suppression and tear-free (frame-aligned) digit updates.
module display_scan_controller #(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_digits,
    input  logic        lz_en,
    input  logic [3:0]  brightness,
    output logic [3:0]  anode,
    output logic [3:0]  one_digit,
    output logic [7:0]  cathode,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] SLOT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] slot_cnt;
    logic [1:0]       r_counter;
    logic [15:0]      shadow_reg;
    logic [15:0]      pending_reg;
    logic             full_reg;

    logic             frame_end;
    logic [3:0]       digit_nib [4];
    logic [3:0]       suppress;
    logic [3:0]       digit_sel;
    logic [3:0]       anode_next;
    logic [7:0]       seg_next;

    assign frame_end = (slot_cnt == SLOT_LAST) && (r_counter == 2'd3);
    assign upd_ready = !full_reg;

    // A digit is suppressible when it and every more-significant digit are zero;
    // the ones digit always stays lit so a value of zero still shows "0".
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign digit_nib[gi] = shadow_reg[4*gi +: 4];
            if (gi == 0) begin : g_ones
                assign suppress[gi] = 1'b0;
            end else begin : g_upper
                assign suppress[gi] = (shadow_reg[15:4*gi] == '0);
            end
        end
    endgenerate

    assign digit_sel = digit_nib[r_counter];

    always_comb begin
        anode_next = 4'hF;
        if ((slot_cnt >= SLOT_BLANK) &&
            !(lz_en && suppress[r_counter]) &&
            ((brightness == 4'hF) || (slot_cnt[3:0] < brightness))) begin
            anode_next = ~(4'b0001 << r_counter);
        end
    end

    always_comb begin
        seg_next = 8'hFF;
        case (digit_sel)
            4'd0: seg_next = 8'hC0;
            4'd1: seg_next = 8'hF9;
            4'd2: seg_next = 8'hA4;
            4'd3: seg_next = 8'hB0;
            4'd4: seg_next = 8'h99;
            4'd5: seg_next = 8'h92;
            4'd6: seg_next = 8'h82;
            4'd7: seg_next = 8'hF8;
            4'd8: seg_next = 8'h80;
            4'd9: seg_next = 8'h90;
            default: seg_next = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt    <= '0;
            r_counter   <= 2'd0;
            shadow_reg  <= 16'h0000;
            pending_reg <= 16'h0000;
            full_reg    <= 1'b0;
            anode       <= 4'hF;
            one_digit   <= 4'h0;
            cathode     <= 8'hFF;
            frame_done  <= 1'b0;
        end else begin
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt  <= '0;
                r_counter <= r_counter + 2'd1;
            end else begin
                slot_cnt <= slot_cnt + CNT_W'(1);
            end

            // Commit only at the frame boundary; a value accepted on that same
            // edge lands in pending and waits for the following boundary.
            if (frame_end && full_reg) begin
                shadow_reg <= pending_reg;
                full_reg   <= 1'b0;
            end else if (upd_valid && !full_reg) begin
                pending_reg <= upd_digits;
                full_reg    <= 1'b1;
            end

            anode      <= anode_next;
            one_digit  <= digit_sel;
            cathode    <= seg_next;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: cycle-accurate behavioural model plus
// directed frame captures and a randomized phase.
module tb_display_scan_controller;

    localparam int RD    = 32;
    localparam int BL    = 4;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        reset;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_digits;
    logic        lz_en;
    logic [3:0]  brightness;
    logic [3:0]  anode;
    logic [3:0]  one_digit;
    logic [7:0]  cathode;
    logic        frame_done;

    always #5 clk = ~clk;

    display_scan_controller #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
        .clk        (clk),
        .reset      (reset),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_digits (upd_digits),
        .lz_en      (lz_en),
        .brightness (brightness),
        .anode      (anode),
        .one_digit  (one_digit),
        .cathode    (cathode),
        .frame_done (frame_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] seg_tab [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    // Model: time since reset release decides slot and digit; shadow/pending
    // follow the accept/commit rules. Expectations formed before an edge are
    // compared against the outputs registered by that edge.
    int          mt;
    logic [15:0] m_shadow, m_pending;
    logic        m_full;
    logic        exp_valid;
    logic [3:0]  e_an, e_dig;
    logic [7:0]  e_ca;
    logic        e_fd;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_anode", anode, 4'hF);
            chk("rst_cathode", cathode, 8'hFF);
            chk("rst_digit", one_digit, 4'h0);
            chk("rst_frame_done", frame_done, 1'b0);
            chk("rst_ready", upd_ready, 1'b1);
            mt = 0; m_shadow = 0; m_pending = 0; m_full = 0; exp_valid = 0;
        end else begin
            int  slot, idx;
            bit  lit;
            if (exp_valid) begin
                chk("anode", anode, e_an);
                chk("one_digit", one_digit, e_dig);
                chk("cathode", cathode, e_ca);
                chk("frame_done", frame_done, e_fd);
            end
            chk("upd_ready", upd_ready, !m_full);
            slot  = mt % RD;
            idx   = (mt / RD) % 4;
            e_dig = 4'(m_shadow >> (4 * idx));
            e_ca  = seg_tab[e_dig];
            lit   = (slot >= BL) &&
                    !(lz_en && idx != 0 && (m_shadow >> (4 * idx)) == 0) &&
                    (brightness == 4'hF || (slot % 16) < brightness);
            e_an  = lit ? 4'(~(1 << idx)) : 4'hF;
            e_fd  = (mt % FRAME) == FRAME - 1;
            if (e_fd && m_full) begin
                m_shadow = m_pending;
                m_full   = 0;
            end else if (upd_valid && !m_full) begin
                m_pending = upd_digits;
                m_full    = 1;
            end
            mt++;
            exp_valid = 1;
        end
    end

    logic [3:0] cap_an  [FRAME];
    logic [3:0] cap_dig [FRAME];
    logic [7:0] cap_ca  [FRAME];
    logic       cap_fd  [FRAME];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fd();
        int n = 0;
        tick();
        while (frame_done !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        chk("frame_done_seen", frame_done, 1'b1);
    endtask

    task automatic offer(logic [15:0] v);
        int n = 0;
        upd_digits = v;
        upd_valid  = 1'b1;
        while (!upd_ready && n < 600) begin
            tick();
            n++;
        end
        chk("offer_ready", upd_ready, 1'b1);
        tick();
        upd_valid = 1'b0;
    endtask

    // Captures one full frame; entry j reflects slot position j of the frame.
    task automatic capture();
        for (int j = 0; j < FRAME; j++) begin
            tick();
            cap_an[j]  = anode;
            cap_dig[j] = one_digit;
            cap_ca[j]  = cathode;
            cap_fd[j]  = frame_done;
        end
    endtask

    function automatic int lit_count(int s);
        int c = 0;
        for (int j = s * RD; j < (s + 1) * RD; j++)
            if (cap_an[j] != 4'hF) c++;
        return c;
    endfunction

    function automatic int fd_count();
        int c = 0;
        for (int j = 0; j < FRAME; j++)
            if (cap_fd[j]) c++;
        return c;
    endfunction

    initial begin
        logic [15:0] d;
        reset = 1'b1; upd_valid = 1'b0; upd_digits = 16'h0; lz_en = 1'b0; brightness = 4'hF;
        repeat (3) tick();
        chk("reset_anode_lit", anode, 4'hF);
        chk("reset_cathode_lit", cathode, 8'hFF);
        chk("reset_ready_lit", upd_ready, 1'b1);
        reset = 1'b0;

        // Scan order with 0x1234 at full brightness.
        offer(16'h1234);
        wait_fd();
        capture();
        chk("scan_blank0", cap_an[0], 4'hF);
        chk("scan_blank3", cap_an[3], 4'hF);
        chk("scan_d1_an", cap_an[4], 4'hE);
        chk("scan_d1_ca", cap_ca[4], 8'h99);
        chk("scan_d1_end", cap_an[31], 4'hE);
        chk("scan_d2_an", cap_an[36], 4'hD);
        chk("scan_d2_ca", cap_ca[36], 8'hB0);
        chk("scan_d3_an", cap_an[68], 4'hB);
        chk("scan_d3_ca", cap_ca[68], 8'hA4);
        chk("scan_d4_an", cap_an[100], 4'h7);
        chk("scan_d4_ca", cap_ca[100], 8'hF9);
        chk("scan_fd_last", cap_fd[FRAME-1], 1'b1);
        chk("scan_fd_once", fd_count(), 1);

        // Tear-free update accepted mid digit2 slot.
        repeat (40) tick();
        offer(16'h5678);
        chk("tear_ready_low", upd_ready, 1'b0);
        chk("tear_old_digit", one_digit, 4'h3);
        wait_fd();
        chk("tear_ready_back", upd_ready, 1'b1);
        capture();
        chk("tear_new_d1", cap_ca[4], 8'h80);
        chk("tear_new_d4", cap_dig[100], 4'h5);

        // Transfer on the boundary edge waits a whole frame.
        repeat (FRAME - 1) tick();
        offer(16'h4321);
        chk("coin_fd", frame_done, 1'b1);
        chk("coin_ready", upd_ready, 1'b0);
        repeat (4) tick();
        chk("coin_not_yet", one_digit, 4'h8);
        wait_fd();
        capture();
        chk("coin_committed", cap_ca[4], 8'hF9);

        // Leading-zero suppression.
        lz_en = 1'b1;
        offer(16'h0040);
        wait_fd();
        capture();
        chk("lz40_d1_cnt", lit_count(0), 28);
        chk("lz40_d1_ca", cap_ca[4], 8'hC0);
        chk("lz40_d2_cnt", lit_count(1), 28);
        chk("lz40_d2_ca", cap_ca[36], 8'h99);
        chk("lz40_d3_cnt", lit_count(2), 0);
        chk("lz40_d4_cnt", lit_count(3), 0);
        offer(16'h0000);
        wait_fd();
        capture();
        chk("lz0_d1_cnt", lit_count(0), 28);
        chk("lz0_d1_ca", cap_ca[4], 8'hC0);
        chk("lz0_d2_cnt", lit_count(1), 0);

        // Brightness 8: slot[3:0] < 8 after blank holds for slots 4-7 and 16-23.
        lz_en = 1'b0;
        brightness = 4'd8;
        wait_fd();
        capture();
        for (int s = 0; s < 4; s++) chk("bright8_cnt", lit_count(s), 12);
        brightness = 4'd0;
        wait_fd();
        capture();
        for (int s = 0; s < 4; s++) chk("bright0_cnt", lit_count(s), 0);

        // Randomized traffic against the model.
        brightness = 4'hF;
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 4; k++)
                d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            upd_digits = d;
            upd_valid  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) brightness = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) lz_en = 1'($urandom_range(0, 1));
            tick();
        end
        upd_valid = 1'b0;

        // Reset during digit3 slot with a pending value.
        brightness = 4'hF;
        lz_en = 1'b0;
        wait_fd();
        repeat (70) tick();
        offer(16'h9999);
        chk("rstmid_full", upd_ready, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_anode", anode, 4'hF);
        chk("rstmid_cathode", cathode, 8'hFF);
        chk("rstmid_ready", upd_ready, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rstrel_blank", anode, 4'hF);
        repeat (4) tick();
        chk("rstrel_d1_an", anode, 4'hE);
        chk("rstrel_d1_ca", cathode, 8'hC0);
        chk("rstrel_ready", upd_ready, 1'b1);
        wait_fd();
        capture();
        chk("rstrel_d2_ca", cap_ca[36], 8'hC0);
        chk("rstrel_d4_dig", cap_dig[100], 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
